// File: rtl/parking_gate_ctrl.sv
// ----------------------------------------------------------------------------
// parking_gate_ctrl
//
// Single-lane parking barrier controller with occupancy counter and a
// two-digit multiplexed 7-segment occupancy display.
//
// The gate is sequenced IDLE -> OPEN_IN/OPEN_OUT -> CLOSE -> IDLE. Entry is
// refused when the lot is full (one-cycle denied pulse). An exit request takes
// priority over a simultaneous entry request. The gate closes either when a
// car passes (count updated) or after GATE_TICKS cycles without a pass
// (count unchanged).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   entry_req  in   car waiting at entry (level, synchronous)
//   exit_req   in   car waiting at exit (level, synchronous)
//   pass       in   car has cleared the barrier (level, synchronous)
//   gate_open  out  barrier raise command (registered)
//   dir_in     out  1 while the gate is open for an entry (registered)
//   full       out  count == CAPACITY
//   denied     out  one-cycle pulse for a refused entry (registered)
//   count      out  current occupancy, 0..CAPACITY
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   AN         out  digit anodes, active-low; only AN[1:0] ever go low
// ----------------------------------------------------------------------------
module parking_gate_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int GATE_TICKS  = 50000000,
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass,
    output logic       gate_open,
    output logic       dir_in,
    output logic       full,
    output logic       denied,
    output logic [6:0] count,
    output logic [6:0] seg,
    output logic [7:0] AN
);

    localparam int TIMER_W = (GATE_TICKS > 2) ? $clog2(GATE_TICKS) : 1;
    localparam int REF_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_TICKS - 1);
    localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
    localparam logic [6:0]         CAP        = 7'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE,
        OPEN_IN,
        OPEN_OUT,
        CLOSE
    } state_t;

    state_t             state_q;
    logic [6:0]         count_q;
    logic [TIMER_W-1:0] timer_q;
    logic               entry_q;
    logic               exit_q;
    logic               gate_open_q;
    logic               dir_in_q;
    logic               denied_q;

    logic [REF_W-1:0]   refresh_q;
    logic [REF_W-1:0]   refresh_d;
    logic               digit_sel_q;
    logic               digit_sel_d;

    logic               entry_rise;
    logic               exit_rise;
    logic               full_w;

    assign entry_rise = entry_req & ~entry_q;
    assign exit_rise  = exit_req & ~exit_q;
    assign full_w     = (count_q == CAP);

    // ------------------------------------------------------------------
    // Gate FSM, occupancy counter, open timer and registered outputs.
    // Edge registers track the request levels in every state, so a request
    // held through a whole gate cycle never produces a second rise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            timer_q     <= '0;
            entry_q     <= 1'b0;
            exit_q      <= 1'b0;
            gate_open_q <= 1'b0;
            dir_in_q    <= 1'b0;
            denied_q    <= 1'b0;
        end else begin
            entry_q     <= entry_req;
            exit_q      <= exit_req;
            gate_open_q <= (state_q == OPEN_IN) || (state_q == OPEN_OUT);
            dir_in_q    <= (state_q == OPEN_IN);
            denied_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    // An accepted exit swallows a coincident entry rise; an
                    // exit at count 0 is ignored and lets the entry through.
                    if (exit_rise && (count_q != 7'd0)) begin
                        state_q <= OPEN_OUT;
                    end else if (entry_rise) begin
                        if (!full_w) begin
                            state_q <= OPEN_IN;
                        end else begin
                            denied_q <= 1'b1;
                        end
                    end
                end
                OPEN_IN, OPEN_OUT: begin
                    // pass has priority over a coincident timeout
                    if (pass) begin
                        state_q <= CLOSE;
                        timer_q <= '0;
                        if (state_q == OPEN_IN) begin
                            count_q <= count_q + 7'd1;
                        end else begin
                            count_q <= count_q - 7'd1;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        state_q <= CLOSE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display digit multiplexing
    // ------------------------------------------------------------------
    always_comb begin
        refresh_d   = refresh_q + 1'b1;
        digit_sel_d = digit_sel_q;
        if (refresh_q == REF_LAST) begin
            refresh_d   = '0;
            digit_sel_d = ~digit_sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q   <= '0;
            digit_sel_q <= 1'b0;
        end else begin
            refresh_q   <= refresh_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] units_w;
    logic [3:0] tens_w;

    assign units_w = 4'(count_q % 7'd10);
    assign tens_w  = 4'(count_q / 7'd10);

    // Tens digit is blanked below 10 while its anode stays enabled.
    always_comb begin
        if (digit_sel_q) begin
            AN  = 8'b11111101;
            seg = (count_q < 7'd10) ? 7'b1111111 : seg7(tens_w);
        end else begin
            AN  = 8'b11111110;
            seg = seg7(units_w);
        end
    end

    assign gate_open = gate_open_q;
    assign dir_in    = dir_in_q;
    assign denied    = denied_q;
    assign full      = full_w;
    assign count     = count_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
module tb_parking_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic       pass;
    logic       gate_open;
    logic       dir_in;
    logic       full;
    logic       denied;
    logic [6:0] count;
    logic [6:0] seg;
    logic [7:0] AN;

    int checks = 0;
    int errors = 0;

    parking_gate_ctrl #(
        .CAPACITY   (12),
        .GATE_TICKS (4),
        .REFRESH_DIV(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .entry_req(entry_req),
        .exit_req (exit_req),
        .pass     (pass),
        .gate_open(gate_open),
        .dir_in   (dir_in),
        .full     (full),
        .denied   (denied),
        .count    (count),
        .seg      (seg),
        .AN       (AN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full gate cycle with a pass; exp_cnt is the occupancy afterwards.
    task automatic car(input bit is_exit, input logic [6:0] exp_cnt);
        if (is_exit) exit_req = 1'b1;
        else         entry_req = 1'b1;
        step();
        step();
        chk("car_gate_open", 8'(gate_open), 8'd1);
        chk("car_dir_in", 8'(dir_in), 8'(!is_exit));
        pass = 1'b1;
        step();
        chk("car_count", 8'(count), 8'(exp_cnt));
        pass      = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        step();
        step();
    endtask

    task automatic wait_an(input logic [7:0] target);
        int n = 0;
        while (AN !== target && n < 20) begin
            step();
            n++;
        end
        chk("an_sync", AN, target);
    endtask

    int high_cnt;

    initial begin
        rst       = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        pass      = 1'b0;

        // Asynchronous reset before the first clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_gate_open", 8'(gate_open), 8'd0);
        chk("rst_dir_in", 8'(dir_in), 8'd0);
        chk("rst_denied", 8'(denied), 8'd0);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_an", AN, 8'hFE);
        chk("rst_seg", 8'(seg), 8'h40);
        step();
        step();
        rst = 1'b0;
        step();

        // Entry with latency checks
        entry_req = 1'b1;
        step();
        chk("entry_gate_n1", 8'(gate_open), 8'd0);
        step();
        chk("entry_gate_n2", 8'(gate_open), 8'd1);
        chk("entry_dir_n2", 8'(dir_in), 8'd1);
        pass = 1'b1;
        step();
        chk("entry_count", 8'(count), 8'd1);
        pass      = 1'b0;
        entry_req = 1'b0;
        step();
        chk("entry_gate_closed", 8'(gate_open), 8'd0);
        step();

        // Timeout: request held, no pass; gate open for exactly 4 cycles
        entry_req = 1'b1;
        step();
        high_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (gate_open === 1'b1) high_cnt++;
        end
        chk("timeout_open_cycles", 8'(high_cnt), 8'd4);
        chk("timeout_count", 8'(count), 8'd1);
        entry_req = 1'b0;
        step();

        // Fill to capacity
        for (int i = 2; i <= 12; i++) car(1'b0, 7'(i));
        chk("full_flag", 8'(full), 8'd1);

        // Display at 12
        wait_an(8'hFE);
        wait_an(8'hFD);
        chk("disp12_tens", 8'(seg), 8'h79);
        step();
        step();
        step();
        chk("disp12_an_hold", AN, 8'hFD);
        step();
        chk("disp12_an_units", AN, 8'hFE);
        chk("disp12_units", 8'(seg), 8'h24);

        // Refused entry
        entry_req = 1'b1;
        step();
        chk("denied_pulse", 8'(denied), 8'd1);
        chk("denied_gate", 8'(gate_open), 8'd0);
        step();
        chk("denied_one_cycle", 8'(denied), 8'd0);
        step();
        chk("denied_gate_stays", 8'(gate_open), 8'd0);
        chk("denied_count", 8'(count), 8'd12);
        entry_req = 1'b0;
        step();

        // Exit from full lot
        car(1'b1, 7'd11);
        chk("exit_full_clear", 8'(full), 8'd0);

        // Simultaneous rises: exit wins, entry dropped
        entry_req = 1'b1;
        exit_req  = 1'b1;
        step();
        chk("simul_denied", 8'(denied), 8'd0);
        step();
        chk("simul_gate", 8'(gate_open), 8'd1);
        chk("simul_dir", 8'(dir_in), 8'd0);
        pass = 1'b1;
        step();
        chk("simul_count", 8'(count), 8'd10);
        pass      = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        step();
        step();
        chk("simul_idle_gate", 8'(gate_open), 8'd0);

        // Down to 5 and check tens blanking
        for (int i = 9; i >= 5; i--) car(1'b1, 7'(i));
        wait_an(8'hFE);
        chk("disp5_units", 8'(seg), 8'h12);
        wait_an(8'hFD);
        chk("disp5_tens_blank", 8'(seg), 8'h7F);

        // Reset in the middle of an open gate
        entry_req = 1'b1;
        step();
        step();
        chk("midrst_pre_gate", 8'(gate_open), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_gate", 8'(gate_open), 8'd0);
        chk("midrst_count", 8'(count), 8'd0);
        chk("midrst_an", AN, 8'hFE);
        chk("midrst_seg", 8'(seg), 8'h40);
        entry_req = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Exit with empty lot is ignored
        exit_req = 1'b1;
        step();
        step();
        step();
        chk("empty_exit_gate", 8'(gate_open), 8'd0);
        chk("empty_exit_count", 8'(count), 8'd0);
        exit_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
